// File: rtl/riscv_pkg.sv
// Shared RV32I constants: format codes, major opcodes, canonical NOP, packed encoder word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // Field-bundle format codes; anything above FMT_J is not a format.
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Major opcodes of the base ISA.
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // ADDI x0, x0, 0 -- substituted for any bundle that cannot be encoded.
  localparam logic [31:0] NOP = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};

  // One FIFO entry: the encoded word and whether it stands in for an illegal bundle.
  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } enc_word_t;

  // 32-bit instructions always carry 2'b11 in the two low opcode bits.
  function automatic logic is_32bit_opcode(input logic [6:0] op);
    return op[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bundle-in / word-out handshake bus of the instruction encoder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; slave is the encoder, master is its environment.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_illegal
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_illegal
  );
endinterface

// File: rtl/instr_pack.sv
// Packs an RV32I field bundle into a 32-bit word, or NOP plus illegal flag (INSTR_ENC_ALIGN_CHECK_EN adds B/J imm[0] check).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [31:0] word;

  // Legality check, then format-specific field placement; illegal bundles collapse to NOP.
  always_comb begin
    illegal = (fmt > FMT_J) || !is_32bit_opcode(opcode);
`ifdef INSTR_ENC_ALIGN_CHECK_EN
    // Branch/jump targets must be halfword aligned; an odd offset is rejected.
    if ((fmt == FMT_B || fmt == FMT_J) && imm[0])
      illegal = 1'b1;
`else
    // imm[0] of B/J offsets has no slot in the word and is simply not used.
`endif
    word = NOP;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP;
    endcase
    instr = illegal ? NOP : word;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into words behind a 2-entry registered FIFO (INSTR_ENC_ALIGN_CHECK_EN: see instr_pack).
// Latency: a bundle accepted at edge N is visible on out_* from the cycle after edge N.
// Backpressure: in_ready is registered (low only when both entries are full), never combinational from out_ready.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,   // entry count; this revision implements exactly two
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t state;
  enc_word_t   packed_w;
  // Second entry; the head entry lives directly in the out_instr/out_illegal registers.
  enc_word_t   spill [DEPTH-1];

  logic push;
  logic pop;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  instr_pack u_pack (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .imm     (bus.in_imm),
    .instr   (packed_w.instr),
    .illegal (packed_w.illegal)
  );

  // FIFO FSM with registered head/valid/ready outputs and the accepted-bundle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= EMPTY;
      bus.out_valid   <= 1'b0;
      bus.out_instr   <= '0;
      bus.out_illegal <= 1'b0;
      bus.in_ready    <= 1'b1;
      spill[0]        <= '0;
      instr_count     <= '0;
    end else begin
      if (push)
        instr_count <= instr_count + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (push) begin
            state           <= ONE;
            bus.out_valid   <= 1'b1;
            bus.out_instr   <= packed_w.instr;
            bus.out_illegal <= packed_w.illegal;
          end
        end
        ONE: begin
          if (push && pop) begin
            bus.out_instr   <= packed_w.instr;
            bus.out_illegal <= packed_w.illegal;
          end else if (push) begin
            // Head is held stable for the stalled consumer; the new word waits behind it.
            state        <= FULL;
            spill[0]     <= packed_w;
            bus.in_ready <= 1'b0;
          end else if (pop) begin
            state           <= EMPTY;
            bus.out_valid   <= 1'b0;
            bus.out_instr   <= '0;
            bus.out_illegal <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state           <= ONE;
            bus.out_instr   <= spill[0].instr;
            bus.out_illegal <= spill[0].illegal;
            bus.in_ready    <= 1'b1;
          end
        end
        default: begin
          state           <= EMPTY;
          bus.out_valid   <= 1'b0;
          bus.out_instr   <= '0;
          bus.out_illegal <= 1'b0;
          bus.in_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized plus directed bench for instr_encoder with a queue-based reference model.
// Latency: model pushes at the accept edge, so the head is compared from the next cycle on.
// Backpressure: model tracks occupancy to predict in_ready and pops on out_valid && out_ready.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int CNT_W = 8;  // narrow so the random phase wraps the counter

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CNT_W-1:0] instr_count;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sent = 0;
  bit armed = 1'b0;

  logic [32:0]      mq[$];   // {illegal, instr} in acceptance order
  logic [CNT_W-1:0] mcnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the field-placement rules, using shifts and masks.
  function automatic logic [32:0] model_enc(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    bit legal;
    legal = (fmt <= 3'd5) && ((op & 7'h3) == 7'h3);
`ifdef INSTR_ENC_ALIGN_CHECK_EN
    if ((fmt == 3'd3 || fmt == 3'd5) && (imm & 32'h1) != 0) legal = 1'b0;
`endif
    if (!legal) return {1'b1, 32'h0000_0013};
    w = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (fmt)
      3'd0: w = w | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: w = w | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
      3'd2: w = w | ((imm & 32'h1F) << 7) | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      3'd3: w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                  | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd4: w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      default: w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 20) & 32'h1) << 31);
    endcase
    return {1'b0, w};
  endfunction

  // Model update at the active edge from bench-driven inputs and the model's own occupancy.
  always @(posedge clk) begin
    bit m_push, m_pop;
    if (reset) begin
      mq.delete();
      mcnt = '0;
    end else begin
      m_push = bus.in_valid && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && bus.out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(model_enc(bus.in_fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7,
                               bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm));
        mcnt = mcnt + 1'b1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    logic [32:0] head;
    if (armed) begin
      head = (mq.size() > 0) ? mq[0] : 33'd0;
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      chk("out_instr", bus.out_instr, head[31:0]);
      chk("out_illegal", 32'(bus.out_illegal), 32'(head[32]));
      chk("instr_count", 32'(instr_count), 32'(mcnt));
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One bundle into an empty encoder, checked one cycle later against a literal, then drained.
  task automatic send_one(input string nm, input logic [2:0] fmt, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic exp_ill);
    step();
    drive(fmt, op, f3, f7, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    sent++;
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_instr"}, bus.out_instr, exp_w);
    chk({nm, "_illegal"}, 32'(bus.out_illegal), 32'(exp_ill));
    chk({nm, "_count"}, 32'(instr_count), 32'(sent));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);

    // Directed encodings with hand-computed words.
    send_one("R_add",  FMT_R, OP_REG,    3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3, 1'b0);
    send_one("I_addi", FMT_I, OP_IMM,    3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd5,         32'h00508093, 1'b0);
    send_one("S_sb",   FMT_S, OP_STORE,  3'd0, 7'd0, 5'd0, 5'd2, 5'd6, 32'd4,         32'h00610223, 1'b0);
    send_one("B_beq",  FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0,         32'h00208063, 1'b0);
    send_one("J_jal",  FMT_J, OP_JAL,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0);
    send_one("U_lui",  FMT_U, OP_LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0);
    send_one("fmt7",   3'd7,  OP_REG,    3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h00000013, 1'b1);
    send_one("badop",  FMT_I, 7'h30,     3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd5,         32'h00000013, 1'b1);
`ifdef INSTR_ENC_ALIGN_CHECK_EN
    send_one("B_odd",  FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3,         32'h00000013, 1'b1);
`else
    send_one("B_odd",  FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3,         32'h00208163, 1'b0);
`endif

    // Backpressure: three bundles offered with the consumer stalled.
    step();
    drive(FMT_R, OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    step();
    drive(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd5);
    step();
    drive(FMT_S, OP_STORE, 3'd0, 7'd0, 5'd0, 5'd2, 5'd6, 32'd4);
    sent += 2;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_instr", bus.out_instr, 32'h002081B3);
      chk("bp_count", 32'(instr_count), 32'(sent));
    end
    bus.out_ready = 1'b1;
    step();
    chk("drain_2nd", bus.out_instr, 32'h00508093);
    chk("drain_count", 32'(instr_count), 32'(sent));
    step();
    sent++;
    chk("drain_3rd", bus.out_instr, 32'h00610223);
    chk("third_accepted", 32'(instr_count), 32'(sent));
    bus.in_valid = 1'b0;
    step();
    chk("drained_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset while FULL, with a concurrent handshake offered.
    drive(FMT_R, OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    step();
    step();
    chk("full_before_rst", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    sent = 0;
    chk("rstfull_valid", 32'(bus.out_valid), 32'd0);
    chk("rstfull_count", 32'(instr_count), 32'd0);
    chk("rstfull_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic, with occasional resets, checked every cycle by the model.
    for (int n = 0; n < 2500; n++) begin
      step();
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      reset         = ($urandom_range(0, 299) == 0);
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0) ? 7'($urandom) : {5'($urandom), 2'b11},
            3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    end
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer entries (fixed at 2 for this revision).
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-instruction counter.
REQ-003 SHALL have ports:
  clk  input  1  rising-edge clock, the only clock.
  reset  input  1  synchronous, active-high reset.
  in_valid  input  1  field bundle valid.
  in_ready  output  1  encoder can accept the bundle.
  in_fmt  input  3  format: 0=R 1=I 2=S 3=B 4=U 5=J.
  in_opcode  input  7  major opcode.
  in_funct3  input  3  funct3.
  in_funct7  input  7  funct7 (R only).
  in_rd, in_rs1, in_rs2  input  5 each  register indices.
  in_imm  input  32  sign-extended immediate, in byte units for B/J.
  out_valid  output  1  encoded word valid.
  out_ready  input  1  consumer accepts word.
  out_instr  output  32  encoded RV32I word.
  out_illegal  output  1  word replaced by NOP due to an illegal bundle.
  instr_count  output  CNT_W  bundles accepted since reset.

Function
REQ-004 SHALL accept a bundle on a cycle with in_valid && in_ready, and accept nothing otherwise.
REQ-005 SHALL encode R as {funct7,rs2,rs1,funct3,rd,opcode}, and I as {imm[11:0],rs1,funct3,rd,opcode}.
REQ-006 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}, and B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-007 SHALL encode U as {imm[31:12],rd,opcode}, and J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-008 SHALL treat a bundle as illegal when in_fmt>5 or in_opcode[1:0]!=2'b11; an illegal bundle SHALL be stored as 32'h00000013 with out_illegal=1.
REQ-009 SHALL hold encoded words in a DEPTH-entry FIFO, registered, with states EMPTY, ONE, FULL.
REQ-010 SHALL present a word accepted at edge N with out_valid=1 from the cycle after edge N (one-cycle latency).
REQ-011 SHALL drive in_ready=1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready to in_ready.
REQ-012 SHALL pop on out_valid && out_ready, with transitions EMPTY->ONE on push; ONE->FULL on push-only; ONE->EMPTY on pop-only; ONE->ONE on push+pop; FULL->ONE on pop.
REQ-013 SHALL keep out_instr and out_illegal stable while out_valid && !out_ready.
REQ-014 SHALL deliver words in acceptance order, with no loss or duplication.
REQ-015 SHALL increment instr_count on every accepted bundle, legal or illegal, and wrap modulo 2^CNT_W.
REQ-016 SHALL drive out_instr=0 and out_illegal=0 whenever out_valid=0.

Reset
REQ-017 SHALL, on reset at a clock edge, set state EMPTY, out_valid=0, out_instr=0, out_illegal=0 and instr_count=0, and drive in_ready=1 from the following cycle.
REQ-018 SHALL discard all buffered words and ignore any concurrent handshake when reset is asserted mid-operation.

Configuration
REQ-019 SHALL, with INSTR_ENC_ALIGN_CHECK_EN defined, also treat B/J bundles with in_imm[0]=1 as illegal (NOP plus out_illegal).
REQ-020 SHALL, without INSTR_ENC_ALIGN_CHECK_EN, silently drop in_imm[0] for B/J.

Structure
REQ-021 SHALL take format codes, the NOP constant 32'h00000013 and opcode constants from shared package riscv_pkg.
REQ-022 SHALL place field packing in combinational sub-module instr_pack (fields in, 32-bit word plus illegal flag out), with the FIFO and FSM in instr_encoder.

Verification
REQ-023 SHALL cover: R fmt=0 op=33 f3=0 f7=0 rd=3 rs1=1 rs2=2 -> out_instr=002081B3 one cycle later; I ADDI rd=1 rs1=1 imm=5 op=13 -> 00508093.
REQ-024 SHALL cover: S op=23 f3=0 rs1=2 rs2=6 imm=4 -> 00610223; B op=63 rs1=1 rs2=2 imm=0 -> 00208063.
REQ-025 SHALL cover: J op=6F rd=1 imm=2048 -> 001000EF; U op=37 rd=5 imm=12345000 -> 123452B7.
REQ-026 SHALL cover: fmt=7 -> 00000013 with out_illegal=1, instr_count incremented; with macro defined, B imm=3 -> NOP and out_illegal=1.
REQ-027 SHALL cover: out_ready=0 with 3 bundles offered -> 2 accepted, in_ready=0, out_instr stable; then out_ready=1 -> words drain in order and the third bundle is accepted.
REQ-028 SHALL cover: reset in FULL -> out_valid=0 and instr_count=0 next cycle, with nothing emitted afterward.
